// File: rtl/grf_scoreboard_pkg.sv
// rtl/grf_scoreboard_pkg.sv - shared constants and types for the GRF scoreboard
package grf_scoreboard_pkg;
   localparam int NREG    = 32;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef logic [4:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/grf_scoreboard_if.sv
// rtl/grf_scoreboard_if.sv - decode issue, writeback release and scoreboard status bundle
interface grf_scoreboard_if
   import grf_scoreboard_pkg::*;
#(
   parameter int NREG = grf_scoreboard_pkg::NREG
);
   logic            issue_valid;
   reg_idx_t        issue_rs;
   reg_idx_t        issue_rt;
   logic            issue_use_rs;
   logic            issue_use_rt;
   logic            issue_wr;
   reg_idx_t        issue_dst;
   logic            wb_valid;
   reg_idx_t        wb_dst;
   logic            stall;
   logic [NREG-1:0] busy;
   logic            idle;
   logic            wb_err;
   logic [31:0]     stall_cycles;

   modport master (
      output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
      output issue_wr, issue_dst, wb_valid, wb_dst,
      input  stall, busy, idle, wb_err, stall_cycles
   );

   modport slave (
      input  issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
      input  issue_wr, issue_dst, wb_valid, wb_dst,
      output stall, busy, idle, wb_err, stall_cycles
   );
endinterface

// File: rtl/grf_sb_entry.sv
// rtl/grf_sb_entry.sv - pending-write counter for one architectural register
module grf_sb_entry
   import grf_scoreboard_pkg::*;
#(
   parameter int CNT_W = grf_scoreboard_pkg::CNT_W
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             wb_hit,
   output logic [CNT_W-1:0] cnt,
   output logic             busy_d,
   output logic             busy,
   output logic             err_dec
);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             busy_q;
   logic             dec;

   // A release and an issue landing together cancel out.
   always_comb begin
      dec     = wb_hit && (cnt_q != '0);
      err_dec = wb_hit && (cnt_q == '0);
      cnt_d   = cnt_q;
      if (inc && !dec) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dec && !inc) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      busy_d  = (cnt_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign cnt  = cnt_q;
   assign busy = busy_q;
endmodule

// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - GRF pending-write scoreboard: decode stall, release tracking, status
module grf_scoreboard
   import grf_scoreboard_pkg::*;
#(
   parameter int NREG  = grf_scoreboard_pkg::NREG,
   parameter int CNT_W = grf_scoreboard_pkg::CNT_W
)(
   input  logic           clk,
   input  logic           reset,
   grf_scoreboard_if.slave sb
);
   localparam logic [CNT_W-1:0] CNT_FULL = '1;

   logic [NREG-1:0][CNT_W-1:0] cnt;
   logic [NREG-1:0]            busy_d;
   logic [NREG-1:0]            busy_q;
   logic [NREG-1:0]            err_dec;

   logic        src_haz;
   logic        ovf_haz;
   logic        stall;
   logic        accept;
   logic        inc;
   logic        wb_live;
   logic        wb_err_q;
   logic        wb_err_d;
   logic        idle_q;
   logic        idle_d;
   logic [31:0] stall_cycles_q;
   logic [31:0] stall_cycles_d;

   assign cnt[0]     = '0;
   assign busy_d[0]  = 1'b0;
   assign busy_q[0]  = 1'b0;
   assign err_dec[0] = 1'b0;

   generate
      for (genvar i = 1; i < NREG; i++) begin : g_entry
         grf_sb_entry #(.CNT_W(CNT_W)) u_entry (
            .clk     (clk),
            .reset   (reset),
            .inc     (inc && (sb.issue_dst == reg_idx_t'(i))),
            .wb_hit  (wb_live && (sb.wb_dst == reg_idx_t'(i))),
            .cnt     (cnt[i]),
            .busy_d  (busy_d[i]),
            .busy    (busy_q[i]),
            .err_dec (err_dec[i])
         );
      end
   endgenerate

   // Hazards look only at registered counts; a same-cycle writeback cannot unblock.
   always_comb begin
      src_haz = (sb.issue_use_rs && (sb.issue_rs != REG_ZERO) && (cnt[sb.issue_rs] != '0)) ||
                (sb.issue_use_rt && (sb.issue_rt != REG_ZERO) && (cnt[sb.issue_rt] != '0));
      ovf_haz = sb.issue_wr && (sb.issue_dst != REG_ZERO) && (cnt[sb.issue_dst] == CNT_FULL);
      stall   = sb.issue_valid && !reset && (src_haz || ovf_haz);
      accept  = sb.issue_valid && !stall && !reset;
      inc     = accept && sb.issue_wr && (sb.issue_dst != REG_ZERO);
      wb_live = sb.wb_valid && (sb.wb_dst != REG_ZERO);

      wb_err_d       = wb_err_q || (|err_dec);
      idle_d         = ~(|busy_d);
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_err_q       <= 1'b0;
         idle_q         <= 1'b1;
         stall_cycles_q <= '0;
      end else begin
         wb_err_q       <= wb_err_d;
         idle_q         <= idle_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign sb.stall        = stall;
   assign sb.busy         = busy_q;
   assign sb.idle         = idle_q;
   assign sb.wb_err       = wb_err_q;
   assign sb.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_grf_scoreboard.sv
// tb/tb_grf_scoreboard.sv - self-checking bench for grf_scoreboard against a counting model
module tb_grf_scoreboard;
   logic clk;
   logic reset;

   grf_scoreboard_if sb_if ();

   grf_scoreboard dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb_if)
   );

   int total = 0;
   int bad   = 0;

   int              m_cnt [32];
   bit              m_err;
   longint unsigned m_stalls;
   logic            obs_stall;
   logic            exp_stall;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic bit m_stall_now();
      bit haz;
      haz = (sb_if.issue_use_rs && sb_if.issue_rs != 0 && m_cnt[sb_if.issue_rs] != 0) ||
            (sb_if.issue_use_rt && sb_if.issue_rt != 0 && m_cnt[sb_if.issue_rt] != 0) ||
            (sb_if.issue_wr && sb_if.issue_dst != 0 && m_cnt[sb_if.issue_dst] == 3);
      return sb_if.issue_valid && !reset && haz;
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] b;
      b = '0;
      for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
      return b;
   endfunction

   task automatic set_issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic wr, input logic [4:0] dst);
      sb_if.issue_valid  = v;
      sb_if.issue_rs     = rs;
      sb_if.issue_rt     = rt;
      sb_if.issue_use_rs = urs;
      sb_if.issue_use_rt = urt;
      sb_if.issue_wr     = wr;
      sb_if.issue_dst    = dst;
   endtask

   task automatic set_wb(input logic v, input logic [4:0] dst);
      sb_if.wb_valid = v;
      sb_if.wb_dst   = dst;
   endtask

   task automatic clear_inputs();
      set_issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      set_wb(1'b0, 5'd0);
   endtask

   // Samples stall mid-cycle, crosses one edge, advances the model, settles 1ns past the edge.
   task automatic tick();
      #1;
      obs_stall = sb_if.stall;
      exp_stall = m_stall_now();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) m_cnt[i] = 0;
         m_err    = 1'b0;
         m_stalls = 0;
      end else begin
         if (exp_stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
         if (sb_if.wb_valid && sb_if.wb_dst != 0) begin
            if (m_cnt[sb_if.wb_dst] == 0) m_err = 1'b1;
            else m_cnt[sb_if.wb_dst]--;
         end
         if (sb_if.issue_valid && !exp_stall && sb_if.issue_wr && sb_if.issue_dst != 0)
            m_cnt[sb_if.issue_dst]++;
      end
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL reset_idle_stall: got %b want 0", obs_stall); end
      end
      total++; if (sb_if.busy !== 32'h0) begin bad++; $display("FAIL reset_busy: got %h want 0", sb_if.busy); end
      total++; if (sb_if.idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", sb_if.idle); end
      total++; if (sb_if.wb_err !== 1'b0) begin bad++; $display("FAIL reset_wb_err: got %b want 0", sb_if.wb_err); end
      total++; if (sb_if.stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_stall_cycles: got %0d want 0", sb_if.stall_cycles); end
   endtask

   task automatic test_raw_hazard();
      do_reset();
      set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8);
      tick();
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL raw_issue_stall: got %b want 0", obs_stall); end
      total++; if (sb_if.busy[8] !== 1'b1) begin bad++; $display("FAIL raw_busy8_set: got %b want 1", sb_if.busy[8]); end
      total++; if (sb_if.idle !== 1'b0) begin bad++; $display("FAIL raw_idle_clear: got %b want 0", sb_if.idle); end
      set_issue(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL raw_wait_stall: got %b want 1", obs_stall); end
      end
      set_wb(1'b1, 5'd8);
      tick();
      total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL raw_same_cycle_wb_stall: got %b want 1", obs_stall); end
      total++; if (sb_if.busy[8] !== 1'b0) begin bad++; $display("FAIL raw_busy8_clear: got %b want 0", sb_if.busy[8]); end
      set_wb(1'b0, 5'd0);
      tick();
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL raw_release_stall: got %b want 0", obs_stall); end
      total++; if (sb_if.stall_cycles !== 32'(m_stalls)) begin bad++; $display("FAIL raw_stall_cycles: got %0d want %0d", sb_if.stall_cycles, m_stalls); end
      total++; if (m_stalls != 4) begin bad++; $display("FAIL raw_model_stalls: got %0d want 4", m_stalls); end
      total++; if (sb_if.idle !== 1'b1) begin bad++; $display("FAIL raw_idle_back: got %b want 1", sb_if.idle); end
      clear_inputs();
   endtask

   task automatic test_overflow();
      do_reset();
      set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL ovf_fill_stall: got %b want 0", obs_stall); end
      end
      tick();
      total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL ovf_fourth_stall: got %b want 1", obs_stall); end
      set_wb(1'b1, 5'd9);
      tick();
      total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL ovf_wb_cycle_stall: got %b want 1", obs_stall); end
      set_wb(1'b0, 5'd0);
      tick();
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL ovf_accept_after_wb: got %b want 0", obs_stall); end
      tick();
      total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL ovf_still_full: got %b want 1", obs_stall); end
      total++; if (sb_if.wb_err !== 1'b0) begin bad++; $display("FAIL ovf_wb_err: got %b want 0", sb_if.wb_err); end
      clear_inputs();
   endtask

   task automatic test_same_cycle();
      do_reset();
      set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5);
      tick();
      set_wb(1'b1, 5'd5);
      tick();
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL same_reg_stall: got %b want 0", obs_stall); end
      total++; if (sb_if.busy[5] !== 1'b1) begin bad++; $display("FAIL same_reg_busy5: got %b want 1", sb_if.busy[5]); end
      clear_inputs();
      set_wb(1'b1, 5'd5);
      tick();
      total++; if (sb_if.busy[5] !== 1'b0) begin bad++; $display("FAIL same_reg_cnt_was_one: got %b want 0", sb_if.busy[5]); end
      total++; if (sb_if.wb_err !== 1'b0) begin bad++; $display("FAIL same_reg_wb_err: got %b want 0", sb_if.wb_err); end
      set_wb(1'b0, 5'd0);
      set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7);
      tick();
      set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6);
      set_wb(1'b1, 5'd7);
      tick();
      total++; if (sb_if.busy[6] !== 1'b1) begin bad++; $display("FAIL diff_reg_busy6: got %b want 1", sb_if.busy[6]); end
      total++; if (sb_if.busy[7] !== 1'b0) begin bad++; $display("FAIL diff_reg_busy7: got %b want 0", sb_if.busy[7]); end
      total++; if (sb_if.busy !== m_busy()) begin bad++; $display("FAIL diff_reg_busy: got %h want %h", sb_if.busy, m_busy()); end
      clear_inputs();
   endtask

   task automatic test_wb_err_and_zero();
      do_reset();
      set_wb(1'b1, 5'd12);
      tick();
      total++; if (sb_if.wb_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", sb_if.wb_err); end
      total++; if (sb_if.busy[12] !== 1'b0) begin bad++; $display("FAIL err_busy12: got %b want 0", sb_if.busy[12]); end
      clear_inputs();
      tick();
      tick();
      total++; if (sb_if.wb_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", sb_if.wb_err); end
      do_reset();
      set_wb(1'b1, 5'd0);
      tick();
      tick();
      total++; if (sb_if.wb_err !== 1'b0) begin bad++; $display("FAIL zero_wb_err: got %b want 0", sb_if.wb_err); end
      set_wb(1'b0, 5'd0);
      set_issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL zero_reg_stall: got %b want 0", obs_stall); end
      end
      total++; if (sb_if.busy !== 32'h0) begin bad++; $display("FAIL zero_reg_busy: got %h want 0", sb_if.busy); end
      total++; if (sb_if.idle !== 1'b1) begin bad++; $display("FAIL zero_reg_idle: got %b want 1", sb_if.idle); end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_wb(1'b1, 5'd12);
      tick();
      set_wb(1'b0, 5'd0);
      for (int r = 3; r <= 5; r++) begin
         set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'(r));
         tick();
      end
      set_issue(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3);
      set_wb(1'b1, 5'd4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL mid_reset_stall: got %b want 0", obs_stall); end
      total++; if (sb_if.busy !== 32'h0) begin bad++; $display("FAIL mid_reset_busy: got %h want 0", sb_if.busy); end
      total++; if (sb_if.idle !== 1'b1) begin bad++; $display("FAIL mid_reset_idle: got %b want 1", sb_if.idle); end
      total++; if (sb_if.wb_err !== 1'b0) begin bad++; $display("FAIL mid_reset_wb_err: got %b want 0", sb_if.wb_err); end
      clear_inputs();
      set_issue(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
      tick();
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL mid_reset_read3: got %b want 0", obs_stall); end
      clear_inputs();
   endtask

   task automatic test_random();
      logic held;
      do_reset();
      held = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!held) begin
            set_issue($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)));
         end
         set_wb($urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)));
         reset = ($urandom_range(0, 59) == 0);
         tick();
         held = obs_stall;
         total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, obs_stall, exp_stall); end
         total++; if (sb_if.busy !== m_busy()) begin bad++; $display("FAIL rnd_busy[%0d]: got %h want %h", n, sb_if.busy, m_busy()); end
         total++; if (sb_if.idle !== (m_busy() == 32'h0)) begin bad++; $display("FAIL rnd_idle[%0d]: got %b want %b", n, sb_if.idle, m_busy() == 32'h0); end
         total++; if (sb_if.wb_err !== m_err) begin bad++; $display("FAIL rnd_wb_err[%0d]: got %b want %b", n, sb_if.wb_err, m_err); end
         total++; if (sb_if.stall_cycles !== 32'(m_stalls)) begin bad++; $display("FAIL rnd_stall_cycles[%0d]: got %0d want %0d", n, sb_if.stall_cycles, m_stalls); end
      end
      reset = 1'b0;
      clear_inputs();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err    = 1'b0;
      m_stalls = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_raw_hazard();
      test_overflow();
      test_same_cycle();
      test_wb_err_and_zero();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/grf_scoreboard.md
# grf_scoreboard

Register-file scoreboard for the 32-entry GRF in the MIPS pipeline. It tracks in-flight writes to each architectural register. It stalls the decode stage when an instruction sources a register with a pending write, or when a register's pending-write counter would overflow. It sits beside D_GRF: issue-side inputs come from decode, release-side inputs come from the writeback port that drives GRF A3/RFWr.

## Interface
Parameters:
- NREG, 32, number of architectural registers (index 0 hardwired zero)
- CNT_W, 2, width of per-register pending counter (max 3 in flight per register)

Ports:
- clk  in  1  clock; everything updates on posedge clk
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rs  in  5  first source register (GRF A1)
- issue_rt  in  5  second source register (GRF A2)
- issue_use_rs  in  1  instruction actually reads rs
- issue_use_rt  in  1  instruction actually reads rt
- issue_wr  in  1  instruction will write a register
- issue_dst  in  5  destination register
- wb_valid  in  1  writeback commits to GRF this cycle (same as RFWr)
- wb_dst  in  5  writeback destination (same as A3)
- stall  out  1  combinational; decode must hold, instruction not accepted
- busy  out  NREG  registered; bit i = counter i nonzero
- idle  out  1  registered; all counters zero
- wb_err  out  1  registered sticky; release seen on a zero counter
- stall_cycles  out  32  registered saturating count of cycles with stall=1

## Operation
- Counter cnt[i] per register; cnt[0] constant 0; busy[0] constant 0.
- Source hazard: src_haz = (use_rs && rs!=0 && cnt[rs]!=0) || (use_rt && rt!=0 && cnt[rt]!=0).
- Overflow hazard: ovf_haz = issue_wr && dst!=0 && cnt[dst]==2^CNT_W-1.
- stall = issue_valid && !reset && (src_haz || ovf_haz).
- accept = issue_valid && !stall && !reset.
- inc = accept && issue_wr && dst!=0.
- dec = wb_valid && wb_dst!=0 && cnt[wb_dst]!=0.
- Counter update is per register:
  - inc only: +1.
  - dec only: -1.
  - both on the same register: unchanged.
  - inc and dec on different registers: both applied.
- wb_valid && wb_dst!=0 && cnt[wb_dst]==0 leaves cnt unchanged and sets wb_err, which stays 1 until reset.
- wb_dst==0 is always ignored and never sets wb_err.
- The hazard check uses registered counters only. A same-cycle writeback does NOT clear a hazard, because the GRF write lands at the end of that cycle's edge.
- busy and idle are recomputed from the next-state counters and registered with them.
- stall_cycles increments each cycle stall=1 and holds at 32'hFFFFFFFF.

## Timing
- Reset values:
  - all cnt = 0, busy = 0, idle = 1, wb_err = 0, stall_cycles = 0.
  - stall = 0 while reset is high.
- Reset mid-operation: all pending state is discarded at the reset edge. Issue and writeback in the reset cycle have no effect.
- Issue latency: an accepted write makes busy[dst]=1 at the next edge. A dependent instruction in the following cycle sees stall=1.
- Release latency: wb at edge N gives cnt-1 after N. A dependent instruction waiting on a counter that reaches 0 gets stall=0 in cycle N+1.
- Stall has zero latency (combinational from inputs and registered counters). Decode holds its inputs stable while stall=1.
- rs==rt, or dst equal to a source, needs no special case. The source check uses the pre-issue count.

## Structure
- Shared package holds:
  - constants NREG=32, CNT_W=2, CNT_MAX=3;
  - a 5-bit register-index type;
  - the zero-register constant.
- Sub-module grf_sb_entry: one counter with inc/dec/err_dec outputs, instantiated NREG-1 times via generate.
- Top holds the hazard logic, the wb_err flag and stall_cycles.

## Test plan
- Reset, then idle 4 cycles -> busy=0, idle=1, stall=0, stall_cycles=0.
- Issue wr dst=8; next cycle issue use_rs rs=8 -> stall=1 until the cycle after wb_dst=8; stall_cycles=number of stalled cycles; busy[8] clears with the wb edge.
- Three back-to-back writes to dst=9 with no wb -> cnt[9]=3; a fourth write to 9 -> stall=1 (ovf). One wb to 9 -> next cycle accepted, cnt stays 3.
- Same cycle: issue write dst=5 and wb_dst=5 with cnt[5]=1 -> cnt[5]=1, busy[5]=1. Separately, issue dst=6 with wb_dst=7 -> both counters updated.
- wb_dst=12 with cnt[12]=0 -> wb_err=1 and sticky. wb_dst=0 -> no change. Issue reading $0 or writing $0 -> never stalls, busy[0]=0.
- Three writes pending to 3/4/5, assert reset one cycle -> all counters 0, wb_err=0, idle=1. A read of rs=3 is accepted immediately after.
